// File: rtl/uart_defs.sv
// Shared UART definitions: TX queue FSM states, default sizing and register map entry.
package uart_defs;

  localparam int UART_DATA_SIZE     = 8;
  localparam int UART_TXQ_DEPTH     = 8;
  localparam int UART_TXQ_GUARD_CYC = 4;

  // TX level register: count_o readback and watermark_i setting
  localparam logic [7:0] UART_TXLVL_R = 8'h1C;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_IDLE = 2'd3
  } type_uart_txq_state_e;

endpackage

// File: rtl/uart_txq_mem.sv
// TX queue storage: synchronous write, asynchronous read, cleared by reset.
module uart_txq_mem
  import uart_defs::*;
#(
  parameter int  DEPTH  = UART_TXQ_DEPTH,
  parameter int  DATA_W = UART_DATA_SIZE,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we_i) mem_d[waddr_i] = wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_q <= '{default: '0};
    else        mem_q <= mem_d;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_tx_queue.sv
// TX byte queue between the register file and uart_tx, issuing one-cycle valid pulses.
// Low-watermark interrupt is built only when UART_TX_QUEUE_WATERMARK_EN is defined.
//
// state     | meaning
// IDLE      | waiting for a queued byte and an idle serializer
// ISSUE     | tx_valid_o high, head byte popped
// WAIT_BUSY | waiting for serializer ready to fall, bounded by the guard timer
// WAIT_IDLE | serializer busy on a frame, waiting for ready to return
module uart_tx_queue
  import uart_defs::*;
#(
  parameter int  DEPTH     = UART_TXQ_DEPTH,
  parameter int  DATA_W    = UART_DATA_SIZE,
  parameter int  GUARD_CYC = UART_TXQ_GUARD_CYC,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              wr_ready_o,
  input  logic              flush_i,
  output logic              tx_valid_o,
  output logic [DATA_W-1:0] tx_data_o,
  input  logic              tx_ready_i,
  output logic [CW-1:0]     count_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              overflow_o,
  input  logic              overflow_clr_i,
  input  logic [CW-1:0]     watermark_i,
  output logic              wm_irq_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int GW = $clog2(GUARD_CYC + 1);

  type_uart_txq_state_e state_q, state_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [GW-1:0] guard_q, guard_d;
  logic          ovf_q, ovf_d;
  logic          full, empty, push, pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  // full is the pre-pop occupancy, so a push against a same-cycle pop is still refused
  assign push  = wr_valid_i & ~full & ~flush_i;
  assign pop   = (state_q == ISSUE) & ~flush_i;

  uart_txq_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data_i),
    .raddr_i (rd_ptr_q),
    .rdata_o (tx_data_o)
  );

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (overflow_clr_i)   ovf_d = 1'b0;
    if (wr_valid_i & full) ovf_d = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    guard_d = guard_q;
    case (state_q)
      IDLE: begin
        // a flush in this cycle empties the queue, so do not issue a stale head
        if (~empty & tx_ready_i & ~flush_i) state_d = ISSUE;
      end
      ISSUE: begin
        state_d = WAIT_BUSY;
        guard_d = GW'(GUARD_CYC - 1);
      end
      WAIT_BUSY: begin
        if (~tx_ready_i)          state_d = WAIT_IDLE;
        else if (guard_q == '0)   state_d = IDLE;
        else                      guard_d = guard_q - GW'(1);
      end
      WAIT_IDLE: begin
        if (tx_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      guard_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      guard_q  <= guard_d;
      ovf_q    <= ovf_d;
    end
  end

  assign tx_valid_o = (state_q == ISSUE);
  assign wr_ready_o = ~full;
  assign full_o     = full;
  assign empty_o    = empty;
  assign count_o    = count_q;
  assign overflow_o = ovf_q;

`ifdef UART_TX_QUEUE_WATERMARK_EN
  logic wm_q, wm_d;

  assign wm_d = (count_q <= watermark_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wm_q <= 1'b0;
    else        wm_q <= wm_d;
  end

  assign wm_irq_o = wm_q;
`else
  logic wm_unused;

  assign wm_unused = ^watermark_i;
  assign wm_irq_o  = 1'b0;
`endif

endmodule
